request_sequencer: RTL and testbench
====================================

// Module: request_sequencer
// PURPOSE
// - Upstream control stage of the traffic-light sequencer: debounces a raw request button and latches requests.
// - Starts one light cycle per request by pulsing enable_out; waits for done_in from the light stage.
// - Holds red for a minimum time, then pulses clear_out to return the light stage to idle.
// PARAMETERS
// DEBOUNCE_CYCLES  4    consecutive stable synchronized samples required to accept a button level change
// MIN_ROSU_SEC     5    red hold after done_in, in 1-second ticks; 0 = no hold
// DIV_FACTOR       10   clk cycles per 1-second tick, same meaning as in the light stage
// TIMEOUT_CYCLES   1000 done_in watchdog limit in clk cycles; used only with WATCHDOG_EN
// PORTS
// clk          in   1  system clock, rising edge
// rst          in   1  asynchronous, active-high reset
// btn_raw      in   1  asynchronous raw request button, active high
// done_in      in   1  light stage "done" level
// enable_out   out  1  one-cycle start pulse to the light stage
// clear_out    out  1  one-cycle clear pulse to the light stage
// busy         out  1  high in every state except S_IDLE
// req_pending  out  1  latched, not-yet-serviced request
// cycle_count  out  8  number of completed cycles, wraps 255 -> 0
// timeout_err  out  1  sticky watchdog flag; constant 0 without WATCHDOG_EN
// BEHAVIOUR
// - Reset (asynchronous, immediate): FSM = S_IDLE. All outputs, synchronizer, debouncer, tick divider and counters = 0.
// - Reset mid-cycle abandons the cycle; no clear_out is issued.
// - Input path: 2-FF synchronizer, then debouncer.
//   - Debounced level btn_db changes after DEBOUNCE_CYCLES consecutive synchronized samples that differ from btn_db.
//   - Any sample equal to btn_db restarts the count.
//   - A rising edge of btn_db sets req_pending on the next clock edge.
//   - Total latency from btn_raw stable high to req_pending = 2+DEBOUNCE_CYCLES+1 cycles (7 with defaults).
// - Request latch:
//   - Single bit, so extra requests while set are coalesced.
//   - Cleared on the S_IDLE->S_START transition.
//   - If a set and a clear occur in the same cycle, the set wins.
// - FSM states and transitions:
//   - S_IDLE: req_pending=1 -> S_START.
//   - S_START: enable_out=1 for exactly this cycle -> S_WAIT_DONE.
//   - S_WAIT_DONE: done_in=1 -> S_HOLD, or S_CLEAR directly if MIN_ROSU_SEC=0.
//   - S_HOLD: tick divider runs -> S_CLEAR after MIN_ROSU_SEC ticks (exactly MIN_ROSU_SEC*DIV_FACTOR cycles in S_HOLD).
//   - S_CLEAR: clear_out=1 for exactly this cycle; cycle_count+1 (mod 256) -> S_IDLE.
// - done_in is ignored in all states except S_WAIT_DONE.
// - Tick divider: zeroed on S_HOLD entry; counts only in S_HOLD.
// - enable_out and clear_out are registered, never asserted together, and each is high at most 1 cycle per light cycle.
// - Back-to-back requests: a request latched during a cycle causes S_IDLE->S_START on the cycle after S_CLEAR.
// CONFIGURATION
// - WATCHDOG_EN defined:
//   - Cycle counter runs in S_WAIT_DONE.
//   - If done_in is still low after TIMEOUT_CYCLES cycles: timeout_err<=1 (sticky until rst) and FSM -> S_CLEAR; that cycle still increments cycle_count.
// - WATCHDOG_EN undefined:
//   - No watchdog logic; S_WAIT_DONE waits indefinitely.
//   - timeout_err tied to 0.
// TESTING
// - Clean press, btn_raw high 20 cycles -> req_pending at cycle 7 -> enable_out 1-cycle pulse -> busy=1.
// - Bounce: btn_raw toggling every 2 cycles for 30 cycles, then low -> req_pending, enable_out and busy stay 0.
// - Full cycle: done_in high 40 cycles after enable_out -> clear_out exactly 50 cycles after S_HOLD entry -> cycle_count=1, busy=0.
// - Second press during S_HOLD -> req_pending=1 -> new enable_out the cycle after S_IDLE is re-entered; cycle_count=2 after it completes.
// - rst pulsed during S_HOLD -> all outputs 0 immediately, no clear_out; later press restarts a normal cycle.
// - WATCHDOG_EN with TIMEOUT_CYCLES=100, done_in never high -> timeout_err=1 and clear_out pulse 100 cycles after S_WAIT_DONE entry.
// - Without WATCHDOG_EN, same stimulus -> FSM stays in S_WAIT_DONE and timeout_err=0.

Source files
------------

// File: rtl/request_sequencer.sv
// request_sequencer: debounces a raw request button, latches requests and runs one light cycle
// per request (start pulse, wait for done, red hold, clear pulse). Optional watchdog: WATCHDOG_EN.
module request_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MIN_ROSU_SEC    = 5,
  parameter int unsigned DIV_FACTOR      = 10,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       done_in,
  output logic       enable_out,
  output logic       clear_out,
  output logic       busy,
  output logic       req_pending,
  output logic [7:0] cycle_count,
  output logic       timeout_err
);

  localparam int unsigned DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DB_LAST  = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
  localparam int unsigned DIV_W    = (DIV_FACTOR > 1) ? $clog2(DIV_FACTOR) : 1;
  localparam int unsigned DIV_LAST = (DIV_FACTOR > 0) ? DIV_FACTOR - 1 : 0;
  localparam int unsigned SEC_W    = (MIN_ROSU_SEC > 1) ? $clog2(MIN_ROSU_SEC) : 1;
  localparam int unsigned SEC_LAST = (MIN_ROSU_SEC > 0) ? MIN_ROSU_SEC - 1 : 0;
  localparam bit          NO_HOLD  = (MIN_ROSU_SEC == 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_HOLD,
    S_CLEAR
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               sync_q1;
  logic               sync_q2;
  logic               btn_db;
  logic               btn_db_q;
  logic               btn_rise;
  logic [DB_W-1:0]    db_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic [SEC_W-1:0]   sec_cnt;
  logic               div_wrap;
  logic               hold_done;
  logic               wd_hit;
  logic               enable_nxt;
  logic               clear_nxt;
  logic               busy_nxt;

  // Two-flop synchronizer feeding a stable-count debouncer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync_q1  <= btn_raw;
      sync_q2  <= sync_q1;
      btn_db_q <= btn_db;
      if (sync_q2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DB_LAST)) begin
        btn_db <= sync_q2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign btn_rise = btn_db & ~btn_db_q;

  // Single-bit request latch; a new press beats the clear on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pending <= 1'b0;
    end else if (btn_rise) begin
      req_pending <= 1'b1;
    end else if (state == S_IDLE) begin
      req_pending <= 1'b0;
    end
  end

  // Red-hold divider: idle at zero outside S_HOLD, so entry always starts from zero
  assign div_wrap  = (div_cnt == DIV_W'(DIV_LAST));
  assign hold_done = div_wrap && (sec_cnt == SEC_W'(SEC_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      sec_cnt <= '0;
    end else if (state != S_HOLD) begin
      div_cnt <= '0;
      sec_cnt <= '0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      sec_cnt <= sec_cnt + SEC_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

`ifdef WATCHDOG_EN
  localparam int unsigned WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned WD_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  logic [WD_W-1:0] wd_cnt;

  assign wd_hit = (state == S_WAIT_DONE) && !done_in && (wd_cnt == WD_W'(WD_LAST));

  // done_in watchdog; the error flag stays set until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != S_WAIT_DONE) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (wd_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state and next-output decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (req_pending) state_nxt = S_START;
      S_START:     state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (done_in) begin
          state_nxt = NO_HOLD ? S_CLEAR : S_HOLD;
        end else if (wd_hit) begin
          state_nxt = S_CLEAR;
        end
      end
      S_HOLD:      if (hold_done) state_nxt = S_CLEAR;
      S_CLEAR:     state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
    enable_nxt = (state_nxt == S_START);
    clear_nxt  = (state_nxt == S_CLEAR);
    busy_nxt   = (state_nxt != S_IDLE);
  end

  // State register with registered pulse/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      enable_out  <= 1'b0;
      clear_out   <= 1'b0;
      busy        <= 1'b0;
      cycle_count <= '0;
    end else begin
      state      <= state_nxt;
      enable_out <= enable_nxt;
      clear_out  <= clear_nxt;
      busy       <= busy_nxt;
      if (state == S_CLEAR) begin
        cycle_count <= cycle_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_request_sequencer.sv
// tb_request_sequencer: random press/done schedules fed from precomputed waveforms; a timeline model
// predicts pulses and status samples, and a negedge monitor scores the DUT against them.
module tb_request_sequencer;

  localparam int unsigned DB    = 4;
  localparam int unsigned MIN_S = 5;
  localparam int unsigned DIV   = 10;
  localparam int unsigned TMO   = 100;
  localparam int          LAT   = 2 + int'(DB) + 1;
  localparam int          HOLD  = int'(MIN_S) * int'(DIV);
  localparam int          MAXC  = 4000;
  localparam int          NR    = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_raw;
  logic       done_in;
  logic       enable_out;
  logic       clear_out;
  logic       busy;
  logic       req_pending;
  logic [7:0] cycle_count;
  logic       timeout_err;

  request_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .MIN_ROSU_SEC   (MIN_S),
    .DIV_FACTOR     (DIV),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .done_in    (done_in),
    .enable_out (enable_out),
    .clear_out  (clear_out),
    .busy       (busy),
    .req_pending(req_pending),
    .cycle_count(cycle_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // kind 0 = enable pulse, 1 = clear pulse; cnt = cycle_count seen during the pulse
  typedef struct { int cyc; int kind; int cnt; } pulse_t;
  // -1 in a field means "not checked"
  typedef struct { int cyc; int busy; int req; int cnt; int terr; } stat_t;

  pulse_t pq[$];
  stat_t  sq[$];
  bit     btn_w  [MAXC];
  bit     done_w [MAXC];
  bit     rst_w  [MAXC];
  int     cyc = -1;
  int     end_cyc;
  int     n_cmp = 0;
  int     n_err = 0;
  bit     done_run = 1'b0;

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void set_btn(int s, int len);
    for (int i = 0; i < len; i++) btn_w[s+i] = 1'b1;
  endfunction

  function automatic void push_pulse(int c, int k, int n);
    pulse_t p;
    p.cyc = c; p.kind = k; p.cnt = n;
    pq.push_back(p);
  endfunction

  function automatic void push_stat(int c, int b, int r, int n, int te);
    stat_t s;
    int i;
    s.cyc = c; s.busy = b; s.req = r; s.cnt = n; s.terr = te;
    i = sq.size();
    while (i > 0 && sq[i-1].cyc > c) i--;
    sq.insert(i, s);
  endfunction

  // Timeline model: one light cycle per round, requests kept as a list of latch-set cycles
  task automatic build();
    int t, f, cnt, bfree, st, len, p, s, h, c, d, l, m, mode;
    int plist[$];
    t = 5; f = 0; cnt = 0; bfree = 0;
    push_stat(0, 0, 0, 0, 0);
    for (int r = 0; r < NR; r++) begin
      if (plist.size() == 0) begin
        st = imax(imax(t, bfree), f);
        if (r == 0 || $urandom_range(0, 2) == 0) begin
          int k;
          bit lvl;
          k = 0; lvl = 1'b1;
          while (k < 30) begin
            int run;
            run = (r == 0) ? 2 : int'($urandom_range(1, 3));
            for (int j = 0; j < run && k < 30; j++) begin
              btn_w[st+k] = lvl;
              k++;
            end
            lvl = !lvl;
          end
          push_stat(st + 38, 0, 0, cnt, 0);
          st += 40;
        end
        len = int'($urandom_range(6, 15));
        set_btn(st, len);
        p = st + LAT;
        plist.push_back(p);
        bfree = st + len + 8;
        push_stat(p, -1, 1, -1, -1);
      end
      p = plist.pop_front();
      s = imax(p, f) + 1;
      while (plist.size() > 0 && plist[0] < s) plist.delete(0);
      push_pulse(s, 0, cnt);
      push_stat(s, 1, -1, cnt, 0);
      d = int'($urandom_range(0, 20));
      l = int'($urandom_range(1, 30));
      for (int i = 0; i < l; i++) done_w[s+1+d+i] = 1'b1;
      h = s + 2 + d;
      c = h + HOLD;
      for (int i = 35; i < 38; i++) done_w[h+i] = 1'b1;
      if (r == NR - 1) begin
        rst_w[h+20] = 1'b1;
        rst_w[h+21] = 1'b1;
        push_stat(h + 20, 0, 0, 0, 0);
        push_stat(h + 21, 0, 0, 0, 0);
        cnt = 0; f = h + 22; t = h + 30;
        plist.delete();
      end else begin
        push_pulse(c, 1, cnt);
        push_stat(c, 1, -1, cnt, 0);
        cnt = (cnt + 1) % 256;
        push_stat(c + 1, 0, -1, cnt, 0);
        f = c + 1; t = c + 2;
        mode = (r == 1) ? 1 : (r == 2) ? 3 : (r == 3) ? 2 : (r == NR - 2) ? 0 :
               int'($urandom_range(0, 3));
        for (int k = 0; k < ((mode == 2) ? 2 : (mode == 0) ? 0 : 1); k++) begin
          m = imax(h + int'($urandom_range(0, (mode == 1) ? 25 : 10)), bfree);
          len = int'($urandom_range(6, 10));
          set_btn(m, len);
          bfree = m + len + 8;
          plist.push_back(m + LAT);
          push_stat(m + LAT, -1, 1, -1, -1);
        end
        if (mode == 3 && bfree <= c + 2 - LAT) begin
          m = c + 2 - LAT;
          set_btn(m, 6);
          bfree = m + 14;
          plist.push_back(m + LAT);
          push_stat(m + LAT, -1, 1, -1, -1);
        end
      end
    end
    st = imax(imax(t, bfree), f);
    set_btn(st, 8);
    p = st + LAT;
    push_stat(p, -1, 1, cnt, 0);
    s = imax(p, f) + 1;
    push_pulse(s, 0, cnt);
`ifdef WATCHDOG_EN
    c = s + 1 + int'(TMO);
    push_stat(c - 1, 1, 0, cnt, 0);
    push_stat(c, 1, 0, cnt, 1);
    push_pulse(c, 1, cnt);
    push_stat(c + 1, 0, 0, (cnt + 1) % 256, 1);
    end_cyc = c + 20;
`else
    push_stat(s + 50, 1, 0, cnt, 0);
    push_stat(s + 1 + int'(TMO) + 5, 1, 0, cnt, 0);
    push_stat(s + 300, 1, 0, cnt, 0);
    end_cyc = s + 310;
`endif
  endtask

  function automatic bit stat_ok(stat_t s);
    if (s.busy >= 0 && int'(busy) != s.busy) return 1'b0;
    if (s.req  >= 0 && int'(req_pending) != s.req) return 1'b0;
    if (s.cnt  >= 0 && int'(cycle_count) != s.cnt) return 1'b0;
    if (s.terr >= 0 && int'(timeout_err) != s.terr) return 1'b0;
    return 1'b1;
  endfunction

  // Monitor: score pulses and scheduled status samples mid-cycle
  always @(negedge clk) begin
    if (cyc >= 0 && !done_run) begin
      while (pq.size() > 0 && pq[0].cyc < cyc) begin
        n_cmp++; n_err++;
        $display("FAIL pulse_missing: kind=%0d required at cycle %0d, still absent at cycle %0d",
                 pq[0].kind, pq[0].cyc, cyc);
        pq.delete(0);
      end
      if (enable_out || clear_out) begin
        n_cmp++;
        if (enable_out && clear_out) begin
          n_err++;
          $display("FAIL pulse_overlap: enable_out and clear_out both high at cycle %0d", cyc);
        end else if (pq.size() == 0) begin
          n_err++;
          $display("FAIL pulse_unexpected: enable=%0b clear=%0b at cycle %0d, none required",
                   enable_out, clear_out, cyc);
        end else begin
          if (pq[0].cyc != cyc || pq[0].kind != (clear_out ? 1 : 0) ||
              cycle_count != 8'(pq[0].cnt)) begin
            n_err++;
            $display("FAIL pulse_check: got cycle %0d kind=%0d count=%0d, required cycle %0d kind=%0d count=%0d",
                     cyc, clear_out, cycle_count, pq[0].cyc, pq[0].kind, pq[0].cnt);
          end
          if (pq[0].cyc == cyc) pq.delete(0);
        end
      end
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
        n_cmp++;
        if (sq[0].cyc != cyc || !stat_ok(sq[0])) begin
          n_err++;
          $display("FAIL status@%0d: busy=%0b req=%0b count=%0d terr=%0b, required busy=%0d req=%0d count=%0d terr=%0d (-1 = any)",
                   sq[0].cyc, busy, req_pending, cycle_count, timeout_err,
                   sq[0].busy, sq[0].req, sq[0].cnt, sq[0].terr);
        end
        sq.delete(0);
      end
    end
  end

  // Driver: replay the precomputed waveforms one cycle at a time
  initial begin
    rst     = 1'b1;
    btn_raw = 1'b0;
    done_in = 1'b0;
    build();
    if (end_cyc > MAXC - 1) end_cyc = MAXC - 1;
    repeat (3) @(posedge clk);
    #1;
    cyc     = 0;
    rst     = rst_w[0];
    btn_raw = btn_w[0];
    done_in = done_w[0];
    while (cyc < end_cyc) begin
      @(posedge clk);
      #1;
      cyc++;
      rst     = rst_w[cyc];
      btn_raw = btn_w[cyc];
      done_in = done_w[cyc];
    end
    @(negedge clk);
    #1;
    done_run = 1'b1;
    while (pq.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL pulse_missing: kind=%0d required at cycle %0d, run ended", pq[0].kind, pq[0].cyc);
      pq.delete(0);
    end
    while (sq.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL status_unchecked: sample at cycle %0d never reached", sq[0].cyc);
      sq.delete(0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
